// File: rtl/dmem_block_mover_pkg.sv
// Shared definitions for the data-memory block mover: state encoding, op codes
// and the copy-direction decision.
package dmem_block_mover_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic OP_COPY = 1'b0;
    localparam logic OP_FILL = 1'b1;

    // Copy runs backward when the destination starts inside the source window,
    // so every source byte is read before it can be overwritten.
    function automatic logic is_backward(input logic op, input logic [7:0] src,
                                         input logic [7:0] dst, input logic [7:0] len);
        logic [7:0] diff;
        diff = dst - src;
        return (op == OP_COPY) && (dst != src) && (diff < len);
    endfunction

endpackage

// File: rtl/dmem_block_mover.sv
// Block-move engine on the data memory port: copies (memmove semantics) or fills
// a byte range after a single start pulse.
module dmem_block_mover
    import dmem_block_mover_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       op,
    input  logic [7:0] src,
    input  logic [7:0] dst,
    input  logic [7:0] len,
    input  logic [7:0] fill_val,
    output logic       busy,
    output logic       done,
    output logic       DW,
    output logic [7:0] A,
    output logic [7:0] D,
    input  logic [7:0] RD,
    output logic [1:0] state_dbg
);

    // Handshake: start is honoured only in IDLE; busy covers every RD/WR cycle,
    // done pulses for one cycle after the last write, and each DW cycle commits
    // at the rising edge that ends it.

    state_t     state, state_nx;
    logic [7:0] src_q, dst_q, cnt_q, hold_q, fill_q;
    logic       op_q, back_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (len == 8'd0)        state_nx = ST_DONE;
                    else if (op == OP_FILL) state_nx = ST_WR;
                    else                    state_nx = ST_RD;
                end
            end
            ST_RD:   state_nx = ST_WR;
            ST_WR: begin
                if (cnt_q == 8'd1)        state_nx = ST_DONE;
                else if (op_q == OP_COPY) state_nx = ST_RD;
                else                      state_nx = ST_WR;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q  <= 8'h00;
            dst_q  <= 8'h00;
            cnt_q  <= 8'h00;
            hold_q <= 8'h00;
            fill_q <= 8'h00;
            op_q   <= OP_COPY;
            back_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        fill_q <= fill_val;
                        cnt_q  <= len;
                        back_q <= is_backward(op, src, dst, len);
                        if (is_backward(op, src, dst, len)) begin
                            src_q <= src + len - 8'd1;
                            dst_q <= dst + len - 8'd1;
                        end else begin
                            src_q <= src;
                            dst_q <= dst;
                        end
                    end
                end
                ST_RD: begin
                    hold_q <= RD;
                    src_q  <= back_q ? src_q - 8'd1 : src_q + 8'd1;
                end
                ST_WR: begin
                    dst_q <= back_q ? dst_q - 8'd1 : dst_q + 8'd1;
                    cnt_q <= cnt_q - 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs depend only on registered state, so they cannot glitch on inputs.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        DW   = 1'b0;
        A    = 8'h00;
        D    = 8'h00;
        case (state)
            ST_RD: begin
                busy = 1'b1;
                A    = src_q;
            end
            ST_WR: begin
                busy = 1'b1;
                DW   = 1'b1;
                A    = dst_q;
                D    = (op_q == OP_FILL) ? fill_q : hold_q;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_dmem_block_mover.sv
// Directed bench for dmem_block_mover: a byte-array memory responder, an
// expected-write queue drained by a monitor, and end-of-transfer checks.
module tb_dmem_block_mover;

    logic       clk;
    logic       rst;
    logic       start;
    logic       op;
    logic [7:0] src, dst, len, fill_val;
    logic       busy, done, DW;
    logic [7:0] A, D, RD;
    logic [1:0] state_dbg;

    logic [7:0]  mem [256];
    logic [15:0] exp_q [$];

    int n_cmp = 0;
    int n_err = 0;
    int busy_cnt, done_cnt, dw_cnt;
    logic [15:0] pat;

    dmem_block_mover dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src(src), .dst(dst),
        .len(len), .fill_val(fill_val), .busy(busy), .done(done), .DW(DW),
        .A(A), .D(D), .RD(RD), .state_dbg(state_dbg)
    );

    // clock / memory responder
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign RD = mem[A];
    always @(posedge clk) if (DW) mem[A] <= D;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_w(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    // monitor: every DW cycle is matched against the next expected write
    always @(negedge clk) begin
        if (rst) begin
            if (busy) begin
                busy_cnt++;
                pat = {pat[14:0], DW};
            end
            if (done) done_cnt++;
            if (DW) begin
                dw_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got A=%h D=%h expected no write", A, D);
                end else begin
                    check("write", {A, D}, exp_q.pop_front());
                end
            end
        end
    end

    // Issue one transfer, optionally poke a second start at cycle poke_at,
    // then check latency, busy length, DW pattern and the single done pulse.
    task automatic run_xfer(input logic o, input logic [7:0] s, input logic [7:0] d,
                            input logic [7:0] n, input logic [7:0] f,
                            input int exp_lat, input int exp_busy,
                            input logic [15:0] exp_pat, input int poke_at);
        int lat;
        @(negedge clk);
        busy_cnt = 0; done_cnt = 0; dw_cnt = 0; pat = 16'h0;
        op = o; src = s; dst = d; len = n; fill_val = f;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = 1'($urandom_range(0, 1));
        src = 8'($urandom_range(0, 255));
        dst = 8'($urandom_range(0, 255));
        len = 8'($urandom_range(1, 255));
        fill_val = 8'($urandom_range(0, 255));
        lat = 1;
        while (!done && lat < 600) begin
            start = (lat == poke_at);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (lat >= 600) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no done after %0d cycles expected %0d", lat, exp_lat);
        end
        check("latency", 16'(lat), 16'(exp_lat));
        check("busy_cycles", 16'(busy_cnt), 16'(exp_busy));
        check("dw_pattern", pat, exp_pat);
        check("dw_count", 16'(dw_cnt), 16'(n));
        repeat (3) @(negedge clk);
        check("done_pulses", 16'(done_cnt), 16'd1);
        check("exp_q_drained", 16'(exp_q.size()), 16'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = ~i[7:0];
        rst = 1'b0; start = 1'b0; op = 1'b0;
        src = 8'h00; dst = 8'h00; len = 8'h00; fill_val = 8'h00;
        #3;
        check("reset_outputs", {11'h0, busy, done, DW, state_dbg}, 16'h0);
        check("reset_addr_data", {A, D}, 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        // fill 0x20..0x23 with A5
        push_w(8'h20, 8'hA5); push_w(8'h21, 8'hA5); push_w(8'h22, 8'hA5); push_w(8'h23, 8'hA5);
        run_xfer(1'b1, 8'h00, 8'h20, 8'd4, 8'hA5, 5, 4, 16'h000F, 0);
        check("fill_mem", {mem[8'h20], mem[8'h23]}, 16'hA5A5);
        check("fill_below", {8'h0, mem[8'h1F]}, 16'h00E0);
        check("fill_above", {8'h0, mem[8'h24]}, 16'h00DB);

        // forward copy 0x10 -> 0x40
        mem[8'h10] = 8'h01; mem[8'h11] = 8'h02; mem[8'h12] = 8'h03; mem[8'h13] = 8'h04;
        push_w(8'h40, 8'h01); push_w(8'h41, 8'h02); push_w(8'h42, 8'h03); push_w(8'h43, 8'h04);
        run_xfer(1'b0, 8'h10, 8'h40, 8'd4, 8'h00, 9, 8, 16'h0055, 0);
        check("fwd_copy_lo", {mem[8'h40], mem[8'h41]}, 16'h0102);
        check("fwd_copy_hi", {mem[8'h42], mem[8'h43]}, 16'h0304);

        // overlapping copy 0x10 -> 0x12 runs backward from 0x15
        mem[8'h10] = 8'h01; mem[8'h11] = 8'h02; mem[8'h12] = 8'h03; mem[8'h13] = 8'h04;
        push_w(8'h15, 8'h04); push_w(8'h14, 8'h03); push_w(8'h13, 8'h02); push_w(8'h12, 8'h01);
        run_xfer(1'b0, 8'h10, 8'h12, 8'd4, 8'h00, 9, 8, 16'h0055, 0);
        check("ovl_copy_lo", {mem[8'h12], mem[8'h13]}, 16'h0102);
        check("ovl_copy_hi", {mem[8'h14], mem[8'h15]}, 16'h0304);

        // wrapping fill FE, FF, 00, 01
        push_w(8'hFE, 8'h5A); push_w(8'hFF, 8'h5A); push_w(8'h00, 8'h5A); push_w(8'h01, 8'h5A);
        run_xfer(1'b1, 8'h00, 8'hFE, 8'd4, 8'h5A, 5, 4, 16'h000F, 0);
        check("wrap_fill", {mem[8'hFF], mem[8'h00]}, 16'h5A5A);

        // zero length: done at T+1, no write, busy never high
        run_xfer(1'b1, 8'h00, 8'h30, 8'd0, 8'h77, 1, 0, 16'h0000, 0);
        check("len0_untouched", {8'h0, mem[8'h30]}, 16'h00CF);

        // reset during the third WR of an 8-byte fill at 0x60
        push_w(8'h60, 8'h33); push_w(8'h61, 8'h33); push_w(8'h62, 8'h33);
        @(negedge clk);
        op = 1'b1; dst = 8'h60; len = 8'd8; fill_val = 8'h33; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_drop", {13'h0, busy, done, DW}, 16'h0);
        check("rst_state", {14'h0, state_dbg}, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        check("rst_written", {mem[8'h60], mem[8'h61]}, 16'h3333);
        check("rst_not_written", {8'h0, mem[8'h62]}, 16'h009D);
        check("rst_exp_q", 16'(exp_q.size()), 16'd0);
        exp_q.delete();

        // normal start after reset
        push_w(8'h62, 8'h44); push_w(8'h63, 8'h44);
        run_xfer(1'b1, 8'h00, 8'h62, 8'd2, 8'h44, 3, 2, 16'h0003, 0);

        // second start while copying is ignored
        mem[8'h80] = 8'h11; mem[8'h81] = 8'h22; mem[8'h82] = 8'h33;
        push_w(8'h90, 8'h11); push_w(8'h91, 8'h22); push_w(8'h92, 8'h33);
        run_xfer(1'b0, 8'h80, 8'h90, 8'd3, 8'h00, 7, 6, 16'h0015, 2);
        check("busy_copy", {mem[8'h90], mem[8'h92]}, 16'h1133);
        check("busy_ignored", {8'h0, mem[8'hA0]}, 16'h005F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
